fact_accel_param: RTL

- Parametrised, bus-mapped factorial accelerator slave; successor to the fixed 64-bit factorial core behind the Top bus decoder.
- Computes N! iteratively with a multi-cycle shift-add multiplier; result held in a 2*DATA_W register pair.
- Additions over the previous core: configurable width and multiply radix, an overflow flag, a busy flag, abort via OPCLEAR, and a deterministic latency formula.
- Sits behind the bus decoder at base 0x7000; the decoder supplies the offset address and the slave select.

---
 rtl/fact_accel_param.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fact_accel_param.sv
// rtl/fact_accel_param.sv - bus-mapped iterative factorial accelerator slave
//
// Computes N! as a chain of shift-add multiplies (acc * factor, factor counting
// down to 2). Each multiply consumes STEP_BITS multiplier bits per cycle, so one
// multiply takes CYC = DATA_W/STEP_BITS cycles. The result is kept modulo
// 2^(2*DATA_W), and a sticky overflow flag records any lost high bits.
//
// Optional feature macro: FACT_CYCCNT_EN adds the CYCCNT register at 0x38.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   s_sel      slave select from the bus decoder
//   s_wr       1 = write, 0 = read
//   s_addr     byte offset within the block
//   s_din      write data
//   s_dout     combinational read data (0 when not reading)
//   interrupt  registered level of done AND intr_en
//
// Register map: 0x00 OPSTART(W) 0x08 OPCLEAR(W) 0x10 STATUS(R: done,busy,overflow)
//               0x18 INTR_EN(R/W) 0x20 OPERAND(R/W) 0x28 RESULT_H(R) 0x30 RESULT_L(R)
//               0x38 CYCCNT(R, FACT_CYCCNT_EN only)

module fact_accel_param #(
  parameter int DATA_W    = 64,
  parameter int STEP_BITS = 1,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);

  localparam int CYC   = DATA_W / STEP_BITS;
  localparam int CNT_W = (CYC > 1) ? $clog2(CYC) : 1;
  localparam int ACC_W = 2 * DATA_W;
  localparam int P_W   = 3 * DATA_W;

  localparam logic [ADDR_W-1:0] A_START  = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_CLEAR  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_INTR   = ADDR_W'(8'h18);
  localparam logic [ADDR_W-1:0] A_OPER   = ADDR_W'(8'h20);
  localparam logic [ADDR_W-1:0] A_RES_H  = ADDR_W'(8'h28);
  localparam logic [ADDR_W-1:0] A_RES_L  = ADDR_W'(8'h30);
`ifdef FACT_CYCCNT_EN
  localparam logic [ADDR_W-1:0] A_CYCCNT = ADDR_W'(8'h38);
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] factor;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  result;
  logic              intr_en;
  logic              done;
  logic              overflow;

  // Multiplier working set: prod accumulates partial products, madd is the
  // multiplicand pre-shifted to the current digit position, mreg holds the
  // multiplier digits still to be consumed (LSB first).
  logic [P_W-1:0]    prod;
  logic [P_W-1:0]    madd;
  logic [DATA_W-1:0] mreg;
  logic [CNT_W-1:0]  cnt;

  logic [P_W-1:0]    partial;
  logic [P_W-1:0]    prod_sum;
  logic [DATA_W-1:0] factor_dec;
  logic              last_step;
  logic              busy;
  logic              wr_en;
  logic              start_req;
  logic              clear_req;

  assign wr_en      = s_sel & s_wr;
  assign start_req  = wr_en && (s_addr == A_START) && s_din[0];
  assign clear_req  = wr_en && (s_addr == A_CLEAR) && s_din[0];
  assign busy       = (state == S_LOAD) || (state == S_MUL);
  assign factor_dec = factor - 1'b1;
  assign last_step  = (cnt == CNT_W'(CYC - 1));

  always_comb begin
    partial = '0;
    for (int b = 0; b < STEP_BITS; b++) begin
      if (mreg[b]) partial = partial + (madd << b);
    end
    prod_sum = prod + partial;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_req) state_nxt = S_LOAD;
      S_LOAD: state_nxt = (factor <= DATA_W'(1)) ? S_DONE : S_MUL;
      S_MUL:  if (last_step && factor_dec == DATA_W'(1)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort has priority over everything, from any state.
    if (clear_req) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      factor   <= '0;
      result   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      prod     <= '0;
      madd     <= '0;
      mreg     <= '0;
      cnt      <= '0;
    end else if (clear_req) begin
      done     <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_req) begin
            acc      <= ACC_W'(1);
            factor   <= operand;
            done     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_LOAD: begin
          cnt  <= '0;
          prod <= '0;
          madd <= P_W'(acc);
          mreg <= factor;
        end
        S_MUL: begin
          if (last_step) begin
            // Multiply complete: commit and immediately arm the next one.
            acc      <= prod_sum[ACC_W-1:0];
            overflow <= overflow | (|prod_sum[P_W-1:ACC_W]);
            factor   <= factor_dec;
            cnt      <= '0;
            prod     <= '0;
            madd     <= P_W'(prod_sum[ACC_W-1:0]);
            mreg     <= factor_dec;
          end else begin
            cnt  <= cnt + 1'b1;
            prod <= prod_sum;
            madd <= madd << STEP_BITS;
            mreg <= mreg >> STEP_BITS;
          end
        end
        S_DONE: begin
          result <= acc;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand is locked while a computation is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operand   <= '0;
      intr_en   <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      if (wr_en && s_addr == A_OPER && !busy) operand <= s_din;
      if (wr_en && s_addr == A_INTR)          intr_en <= s_din[0];
      interrupt <= done & intr_en;
    end
  end

`ifdef FACT_CYCCNT_EN
  logic [DATA_W-1:0] cyccnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               cyccnt <= '0;
    else if (clear_req)                         cyccnt <= '0;
    else if (state == S_IDLE && start_req)      cyccnt <= '0;
    else if (busy)                              cyccnt <= cyccnt + 1'b1;
  end
`endif

  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr) begin
      case (s_addr)
        A_STATUS: s_dout = {{(DATA_W-3){1'b0}}, overflow, busy, done};
        A_INTR:   s_dout = {{(DATA_W-1){1'b0}}, intr_en};
        A_OPER:   s_dout = operand;
        A_RES_H:  s_dout = result[ACC_W-1:DATA_W];
        A_RES_L:  s_dout = result[DATA_W-1:0];
`ifdef FACT_CYCCNT_EN
        A_CYCCNT: s_dout = cyccnt;
`endif
        default:  s_dout = '0;
      endcase
    end
  end

endmodule
